// File: rtl/aixh_mxc_upper_seq.sv
// Upper-array job sequencer: sync pulse, command beats, backward drain, done/err report.
// Optional drain watchdog compiled in with AIXH_MXC_UPPER_SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a job, stray backward beats flag an error
// SYNC  | one-cycle csync pulse to the array
// ISSUE | latched command driven for len cycles
// DRAIN | wait for exp backward beats (or watchdog)
// DONE  | one-cycle o_done / o_err report
module aixh_mxc_upper_seq #(
    parameter int CMD_W   = 32,
    parameter int BWD_DW  = 64,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              aixh_core_clk,
    input  logic              aixh_core_rst,
    input  logic              i_req_vld,
    output logic              o_req_rdy,
    input  logic [CMD_W-1:0]  i_req_cmd,
    input  logic [LEN_W-1:0]  i_req_len,
    input  logic [LEN_W-1:0]  i_req_exp,
    output logic              o_fwd_csync,
    output logic [CMD_W-1:0]  o_fwd_cmd,
    input  logic              i_bwd_vld,
    input  logic [BWD_DW-1:0] i_bwd_dat,
    output logic              o_res_vld,
    output logic [BWD_DW-1:0] o_res_dat,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state;
    logic [CMD_W-1:0]   cmd_q;
    logic [LEN_W-1:0]   exp_q;
    logic [LEN_W-1:0]   rem_cnt;
    logic [LEN_W-1:0]   bwd_cnt;
    logic               err_flag;

    logic               in_count;
    logic               bwd_hit;
    logic               bwd_over;
    logic [LEN_W-1:0]   bwd_cnt_nxt;
    logic               wd_expired;

    assign o_req_rdy = (state == IDLE);
    assign o_busy    = (state != IDLE);

    // Beat arriving this cycle is folded into the count before the drain compare.
    always_comb begin
        in_count    = (state == SYNC) || (state == ISSUE) || (state == DRAIN);
        bwd_hit     = in_count && i_bwd_vld;
        bwd_over    = bwd_hit && (bwd_cnt >= exp_q);
        bwd_cnt_nxt = bwd_cnt;
        if (bwd_hit && (bwd_cnt != {LEN_W{1'b1}}))
            bwd_cnt_nxt = bwd_cnt + LEN_W'(1);
    end

`ifdef AIXH_MXC_UPPER_SEQ_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WD_W-1:0] wd_cnt;
    assign wd_expired = (wd_cnt == '0);
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge aixh_core_clk) begin
        if (aixh_core_rst) begin
            state       <= IDLE;
            cmd_q       <= '0;
            exp_q       <= '0;
            rem_cnt     <= '0;
            bwd_cnt     <= '0;
            err_flag    <= 1'b0;
            o_fwd_csync <= 1'b0;
            o_fwd_cmd   <= '0;
            o_res_vld   <= 1'b0;
            o_res_dat   <= '0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
`ifdef AIXH_MXC_UPPER_SEQ_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
        end else begin
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            o_res_vld <= bwd_hit;
            if (bwd_hit)
                o_res_dat <= i_bwd_dat;
            bwd_cnt <= bwd_cnt_nxt;
            if (bwd_over || (i_bwd_vld && !in_count))
                err_flag <= 1'b1;

            case (state)
                IDLE: begin
                    if (i_req_vld) begin
                        cmd_q       <= i_req_cmd;
                        rem_cnt     <= i_req_len;
                        exp_q       <= i_req_exp;
                        bwd_cnt     <= '0;
                        o_fwd_csync <= 1'b1;
                        state       <= SYNC;
                    end
                end
                SYNC: begin
                    o_fwd_csync <= 1'b0;
                    if (rem_cnt != '0) begin
                        o_fwd_cmd <= cmd_q;
                        state     <= ISSUE;
                    end else begin
                        state     <= DRAIN;
`ifdef AIXH_MXC_UPPER_SEQ_TIMEOUT_EN
                        wd_cnt    <= WD_W'(TIMEOUT - 1);
`endif
                    end
                end
                ISSUE: begin
                    rem_cnt <= rem_cnt - LEN_W'(1);
                    if (rem_cnt == LEN_W'(1)) begin
                        o_fwd_cmd <= '0;
                        state     <= DRAIN;
`ifdef AIXH_MXC_UPPER_SEQ_TIMEOUT_EN
                        wd_cnt    <= WD_W'(TIMEOUT - 1);
`endif
                    end
                end
                DRAIN: begin
                    if (bwd_cnt_nxt >= exp_q) begin
                        o_done   <= 1'b1;
                        o_err    <= err_flag || bwd_over;
                        err_flag <= 1'b0;
                        state    <= DONE;
                    end else if (wd_expired) begin
                        o_done   <= 1'b1;
                        o_err    <= 1'b1;
                        err_flag <= 1'b0;
                        state    <= DONE;
                    end
`ifdef AIXH_MXC_UPPER_SEQ_TIMEOUT_EN
                    else begin
                        wd_cnt <= wd_cnt - WD_W'(1);
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aixh_mxc_upper_seq.sv
// Directed bench for aixh_mxc_upper_seq: job vector table plus reset, stray-beat
// and drain-watchdog sequences (watchdog expectations follow AIXH_MXC_UPPER_SEQ_TIMEOUT_EN).
module tb_aixh_mxc_upper_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_vld;
    logic        o_req_rdy;
    logic [31:0] i_req_cmd;
    logic [15:0] i_req_len;
    logic [15:0] i_req_exp;
    logic        o_fwd_csync;
    logic [31:0] o_fwd_cmd;
    logic        i_bwd_vld;
    logic [63:0] i_bwd_dat;
    logic        o_res_vld;
    logic [63:0] o_res_dat;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    aixh_mxc_upper_seq #(
        .CMD_W(32), .BWD_DW(64), .LEN_W(16), .TIMEOUT(16)
    ) dut (
        .aixh_core_clk(clk),
        .aixh_core_rst(rst),
        .i_req_vld(i_req_vld),
        .o_req_rdy(o_req_rdy),
        .i_req_cmd(i_req_cmd),
        .i_req_len(i_req_len),
        .i_req_exp(i_req_exp),
        .o_fwd_csync(o_fwd_csync),
        .o_fwd_cmd(o_fwd_cmd),
        .i_bwd_vld(i_bwd_vld),
        .i_bwd_dat(i_bwd_dat),
        .o_res_vld(o_res_vld),
        .o_res_dat(o_res_dat),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_err(o_err)
    );

    typedef struct {
        string       name;
        logic [15:0] len;
        logic [15:0] exp;
        logic [31:0] cmd;
        logic [31:0] beats;    // bit k: backward beat during cycle T+k
        int          done_at;  // cycle offset of o_done, -1 = never
        int          err;
        int          res_n;
    } vec_t;

    function automatic logic [63:0] pat(input int k);
        return {32'hD00D_0000, 32'(k)};
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input vec_t v);
        int csync_at, csync_n, cmd_n, cmd_first, cmd_bad, res_n, res_bad, done_at, err_v, cyc;
        csync_at = -1; csync_n = 0; cmd_n = 0; cmd_first = -1; cmd_bad = 0;
        res_n = 0; res_bad = 0; done_at = -1; err_v = -1;
        chk({v.name, ".rdy"}, int'(o_req_rdy), 1);
        i_req_vld = 1'b1;
        i_req_cmd = v.cmd;
        i_req_len = v.len;
        i_req_exp = v.exp;
        for (int k = 0; k < 80; k++) begin
            i_bwd_vld = (k < 32) ? v.beats[k] : 1'b0;
            i_bwd_dat = pat(k);
            step();
            i_req_vld = 1'b0;
            i_bwd_vld = 1'b0;
            cyc = k + 1;
            if (o_fwd_csync) begin
                csync_n++;
                if (csync_at < 0) csync_at = cyc;
            end
            if (o_fwd_cmd != '0) begin
                cmd_n++;
                if (cmd_first < 0) cmd_first = cyc;
                if (o_fwd_cmd != v.cmd) cmd_bad++;
            end
            if (o_res_vld) begin
                res_n++;
                if (o_res_dat != pat(k)) res_bad++;
            end
            if (o_done) begin
                done_at = cyc;
                err_v   = int'(o_err);
                break;
            end
        end
        chk({v.name, ".csync_at"}, csync_at, 1);
        chk({v.name, ".csync_n"}, csync_n, 1);
        chk({v.name, ".cmd_beats"}, cmd_n, int'(v.len));
        chk({v.name, ".cmd_first"}, cmd_first, (v.len != 0) ? 2 : -1);
        chk({v.name, ".cmd_value_errs"}, cmd_bad, 0);
        chk({v.name, ".res_n"}, res_n, v.res_n);
        chk({v.name, ".res_dat_errs"}, res_bad, 0);
        chk({v.name, ".done_at"}, done_at, v.done_at);
        chk({v.name, ".err"}, err_v, v.err);
        chk({v.name, ".busy_in_done"}, int'(o_busy), 1);
        step();
        chk({v.name, ".rdy_after"}, int'(o_req_rdy), 1);
        chk({v.name, ".busy_after"}, int'(o_busy), 0);
    endtask

    vec_t vecs[5];
    vec_t stray_job;
    vec_t wd_job;
    int   seen_done;

    initial begin
        vecs[0] = '{"basic_len3_exp2", 16'd3, 16'd2, 32'h0000_00A5, 32'h0000_000C, 6, 0, 2};
        vecs[1] = '{"len0_exp0",       16'd0, 16'd0, 32'h1234_5678, 32'h0000_0000, 3, 0, 0};
        vecs[2] = '{"overflow_exp1",   16'd3, 16'd1, 32'h0000_0077, 32'h0000_001C, 6, 1, 3};
        vecs[3] = '{"sync_beat_late",  16'd2, 16'd3, 32'hCAFE_0001, 32'h0000_0052, 7, 0, 3};
        vecs[4] = '{"len1_exp1",       16'd1, 16'd1, 32'h8000_0000, 32'h0000_0008, 4, 0, 1};
        stray_job = '{"after_stray",   16'd1, 16'd0, 32'h0000_0011, 32'h0000_0000, 4, 1, 0};

        rst = 1'b1; i_req_vld = 1'b0; i_req_cmd = '0; i_req_len = '0; i_req_exp = '0;
        i_bwd_vld = 1'b0; i_bwd_dat = '0;
        repeat (3) step();
        chk("reset.csync", int'(o_fwd_csync), 0);
        chk("reset.cmd", int'(o_fwd_cmd != '0), 0);
        chk("reset.res_vld", int'(o_res_vld), 0);
        chk("reset.res_dat", int'(o_res_dat != '0), 0);
        chk("reset.busy", int'(o_busy), 0);
        chk("reset.done", int'(o_done), 0);
        chk("reset.err", int'(o_err), 0);
        rst = 1'b0;
        chk("reset.rdy_release", int'(o_req_rdy), 1);
        step();

        for (int i = 0; i < 5; i++) run_job(vecs[i]);

        // Stray beat in IDLE is dropped and flagged on the next job only.
        i_bwd_vld = 1'b1; i_bwd_dat = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        i_bwd_vld = 1'b0;
        chk("stray.no_res_vld", int'(o_res_vld), 0);
        chk("stray.idle", int'(o_busy), 0);
        run_job(stray_job);
        stray_job.name = "clean_after_stray";
        stray_job.err  = 0;
        run_job(stray_job);

        // Reset in the middle of a long ISSUE phase.
        i_req_vld = 1'b1; i_req_cmd = 32'h0000_5A5A; i_req_len = 16'd10; i_req_exp = 16'd0;
        step();
        i_req_vld = 1'b0;
        repeat (3) step();
        chk("mid_rst.issuing", int'(o_fwd_cmd), 32'h5A5A);
        rst = 1'b1;
        step();
        chk("mid_rst.cmd_zero", int'(o_fwd_cmd), 0);
        chk("mid_rst.busy", int'(o_busy), 0);
        chk("mid_rst.done", int'(o_done), 0);
        rst = 1'b0;
        chk("mid_rst.rdy", int'(o_req_rdy), 1);
        seen_done = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (o_done || o_fwd_cmd != '0) seen_done++;
        end
        chk("mid_rst.quiet", seen_done, 0);

`ifdef AIXH_MXC_UPPER_SEQ_TIMEOUT_EN
        wd_job = '{"watchdog", 16'd0, 16'd4, 32'h0000_0001, 32'h0000_0002, 18, 1, 1};
        run_job(wd_job);
`else
        // Without the watchdog, a short drain hangs until reset.
        i_req_vld = 1'b1; i_req_cmd = 32'h1; i_req_len = 16'd0; i_req_exp = 16'd4;
        step();
        i_req_vld = 1'b0;
        i_bwd_vld = 1'b1; i_bwd_dat = 64'h1;
        step();
        i_bwd_vld = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (o_done || !o_busy) seen_done++;
        end
        chk("no_watchdog.hang", seen_done, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("no_watchdog.rdy_after_rst", int'(o_req_rdy), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aixh_mxc_upper_seq.md
AIXH_MXC_UPPER_SEQ -- requirements
Module: aixh_mxc_upper_seq

Interface
REQ-001 Parameter CMD_W, default 32: width of the forward command word driven into the upper array.
REQ-002 Parameter BWD_DW, default 64: width of the backward result data.
REQ-003 Parameter LEN_W, default 16: width of the beat-count and expected-count fields.
REQ-004 Parameter TIMEOUT, default 1024: drain watchdog limit in cycles; used only when the watchdog is compiled in (REQ-032).
REQ-005 Port aixh_core_clk, input, 1 bit: the single clock; every flop in the block is clocked on its rising edge.
REQ-006 Port aixh_core_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port i_req_vld, input, 1 bit: a job request is offered.
REQ-008 Port o_req_rdy, output, 1 bit: the block accepts a job in this cycle.
REQ-009 Port i_req_cmd, input, CMD_W bits: the command word for the job.
REQ-010 Port i_req_len, input, LEN_W bits: the number of command beats to issue.
REQ-011 Port i_req_exp, input, LEN_W bits: the number of backward beats the job expects.
REQ-012 Port o_fwd_csync, output, 1 bit: sync pulse to the array.
REQ-013 Port o_fwd_cmd, output, CMD_W bits: command to the array; all-zero means NOP.
REQ-014 Port i_bwd_vld, input, 1 bit, and port i_bwd_dat, input, BWD_DW bits: backward beat from the array; this input has no backpressure.
REQ-015 Port o_res_vld, output, 1 bit, and port o_res_dat, output, BWD_DW bits: registered copy of each counted backward beat.
REQ-016 Port o_busy, output, 1 bit: the state is not IDLE.
REQ-017 Ports o_done, output, 1 bit, and o_err, output, 1 bit: pulses that mark the end of a job and its error status.

Function
REQ-018 The FSM SHALL have the states IDLE, SYNC, ISSUE, DRAIN and DONE.
REQ-019 o_req_rdy SHALL be 1 only in IDLE, decoded combinationally from the state; a job is accepted when i_req_vld and o_req_rdy are both 1.
REQ-020 On accept, the block SHALL latch cmd, len and exp, clear the beat and backward counters, and go to SYNC.
REQ-021 In SYNC, o_fwd_csync SHALL be 1 for exactly one cycle while o_fwd_cmd is 0.
REQ-022 After SYNC, the next state SHALL be ISSUE if len is not 0, otherwise DRAIN.
REQ-023 In ISSUE, o_fwd_cmd SHALL equal the latched cmd for exactly len consecutive cycles, then the FSM SHALL go to DRAIN.
- Accept at cycle T gives csync at T+1 and command beats at T+2 through T+1+len.
- All forward outputs are registered.
REQ-024 Outside ISSUE, o_fwd_cmd SHALL be 0; outside SYNC, o_fwd_csync SHALL be 0.
REQ-025 In SYNC, ISSUE and DRAIN, each i_bwd_vld beat SHALL increment the backward counter and SHALL produce o_res_vld one cycle later with o_res_dat equal to i_bwd_dat.
- A beat that arrives after the counter already equals exp SHALL set the error flag and SHALL still be forwarded on o_res_vld and o_res_dat.
REQ-026 The FSM SHALL leave DRAIN for DONE in the first cycle in which the backward count is at least exp.
- exp equal to 0 therefore spends exactly one cycle in DRAIN.
REQ-027 A backward beat that arrives in the same cycle as the DRAIN-to-DONE transition SHALL be counted before the comparison.
REQ-028 DONE SHALL last one cycle: o_done is 1 and o_err carries the error flag; the next state is IDLE.
REQ-029 A backward beat that arrives in IDLE or DONE SHALL be dropped: no o_res_vld, no count change, and it SHALL set the error flag reported on the next job's o_done.
REQ-030 The LEN_W counters SHALL saturate and SHALL never wrap.

Reset
REQ-031 While aixh_core_rst is 1, on the clock edge, the block SHALL go to IDLE, clear all counters and the error flag, and drive o_fwd_csync, o_fwd_cmd, o_res_vld, o_done, o_err and o_busy to 0; o_res_dat SHALL be 0.
- Reset asserted in any state aborts the job with no o_done.
- o_req_rdy SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-032 Macro AIXH_MXC_UPPER_SEQ_TIMEOUT_EN selects the drain watchdog.
- Defined: a counter clears on entry to DRAIN; after TIMEOUT cycles in DRAIN without reaching exp, the FSM SHALL go to DONE with o_err set to 1.
- Undefined: no watchdog logic exists and DRAIN waits indefinitely.

Verification
REQ-033 len=3, exp=2, cmd=0xA5, two backward beats during ISSUE -> csync at T+1, 0xA5 at T+2 to T+4, two o_res_vld, o_done=1 and o_err=0 at T+6.
REQ-034 len=0, exp=0 -> csync at T+1, DRAIN for one cycle, o_done at T+3, o_fwd_cmd stays 0 throughout.
REQ-035 exp=1 with three backward beats -> three o_res_vld beats and o_err=1 on o_done.
REQ-036 Reset pulsed in the middle of ISSUE with len=10 -> o_fwd_cmd is 0 in the next cycle, no o_done, o_req_rdy=1 after release.
REQ-037 With AIXH_MXC_UPPER_SEQ_TIMEOUT_EN defined and TIMEOUT=16, exp=4 with 1 beat -> o_done with o_err=1 exactly 16 cycles after DRAIN entry; with the macro undefined, o_busy stays 1.
REQ-038 A backward beat in IDLE followed by a clean job -> no o_res_vld for the stray beat and o_err=1 on that job's o_done.
